vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The block SHALL have port CLK, input, 1, pixel clock (25 MHz nominal).
REQ-010 The block SHALL have port RST, input, 1, reset: synchronous, active-low, sampled on CLK.
REQ-011 The block SHALL have port col, output, 10, horizontal position; 0..H_TOTAL-1.
REQ-012 The block SHALL have port row, output, 10, vertical position; 0..V_TOTAL-1.
REQ-013 The block SHALL have port hsync, output, 1, horizontal sync; active-low.
REQ-014 The block SHALL have port vsync, output, 1, vertical sync; active-low.
REQ-015 The block SHALL have port de, output, 1, high when col<H_ACTIVE and row<V_ACTIVE.
REQ-016 The block SHALL have port frame_tick, output, 1, one-clock pulse at start of vertical blank.
REQ-017 The block SHALL have port step, output, 1, one-clock pulse advancing downstream logistic-map iterators.
REQ-018 With VGA_STEP_DIV_EN defined, the block SHALL have port step_div, input, 8, frame divider for step.

Function
REQ-019 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-020 Each clock, col SHALL increment by 1, and wrap from H_TOTAL-1 to 0.
REQ-021 Row SHALL increment only on the col wrap, and wrap from V_TOTAL-1 to 0 on the same edge that col wraps.
REQ-022 hsync SHALL be 0 exactly when H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC (656..751), else 1.
REQ-023 vsync SHALL be 0 exactly when V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC (490..491), else 1.
REQ-024 hsync, vsync, de and frame_tick SHALL be registered and aligned with the col/row value presented in the same cycle; zero skew.
REQ-025 frame_tick SHALL be 1 for exactly the one cycle where col==0 and row==V_ACTIVE, once per frame.
REQ-026 Outputs SHALL have no glitches: all outputs come directly from flops.

Reset
REQ-027 While RST==0 at a CLK edge, the block SHALL set col=0, row=0, hsync=1, vsync=1, de=1, frame_tick=0 and step=0, and clear the frame divider counter to 0.
REQ-028 On the first edge with RST==1, col SHALL become 1 and normal counting SHALL proceed.
REQ-029 Reset asserted mid-line or mid-frame SHALL abort the frame immediately with no partial sync pulse extended.

Configuration
REQ-030 Macro VGA_STEP_DIV_EN SHALL select the step behaviour.
REQ-031 When VGA_STEP_DIV_EN is defined, an 8-bit frame counter SHALL count frame_tick pulses.
  - step SHALL pulse coincident with the frame_tick that brings the count to step_div; the counter then clears to 0.
  - step_div=0 SHALL make step pulse on every frame_tick.
  - step_div SHALL be sampled at each frame_tick.
  - A step_div change to a value below the current count SHALL cause step to pulse on the next frame_tick and the counter to clear.
REQ-032 When VGA_STEP_DIV_EN is undefined, step SHALL equal frame_tick and no step_div port or counter SHALL exist.

Verification
REQ-033 Reset release, 800 clocks -> col runs 1..799,0; row becomes 1 on the wrap; hsync low for exactly 96 clocks starting at col=656.
REQ-034 Full frame of 420000 clocks -> row wraps 524->0 with col 799->0; vsync low for 1600 clocks starting at row=490, col=0.
REQ-035 de count over one frame == 307200; de=0 at (640,0) and at (0,480); de=1 at (639,479).
REQ-036 3 frames -> exactly 3 frame_tick pulses, each at (0,480); with the macro undefined, step is identical to frame_tick.
REQ-037 VGA_STEP_DIV_EN with step_div=2 over 9 frames -> step on the 3rd, 6th and 9th frame_tick only; with step_div=0 -> step on every frame_tick.
REQ-038 RST=0 pulse at (700,200) during hsync -> next cycle col=0, row=0, hsync=1, vsync=1, frame_tick=0, divider cleared.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: col/row counters with registered sync, data-enable, frame and step pulses.
// Define VGA_STEP_DIV_EN to add the step_div input and an 8-bit frame divider for step.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       CLK,
  input  logic       RST,
`ifdef VGA_STEP_DIV_EN
  input  logic [7:0] step_div,
`endif
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_tick,
  output logic       step
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HAct     = 10'(H_ACTIVE);
  localparam logic [9:0] VAct     = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic       ft_q, ft_d;
  logic       step_q, step_d;

  // Decoded outputs are derived from the next position so they land with it.
  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (col_q == HLast) begin
      col_d = 10'd0;
      if (row_q == VLast) begin
        row_d = 10'd0;
      end else begin
        row_d = row_q + 10'd1;
      end
    end
    hsync_d = !((col_d >= HsStart) && (col_d < HsEnd));
    vsync_d = !((row_d >= VsStart) && (row_d < VsEnd));
    de_d    = (col_d < HAct) && (row_d < VAct);
    ft_d    = (col_d == 10'd0) && (row_d == VAct);
  end

`ifdef VGA_STEP_DIV_EN
  logic [7:0] div_cnt_q, div_cnt_d;

  // >= rather than == so lowering step_div below the count fires on the next tick.
  always_comb begin
    div_cnt_d = div_cnt_q;
    step_d    = 1'b0;
    if (ft_d) begin
      if (div_cnt_q >= step_div) begin
        step_d    = 1'b1;
        div_cnt_d = 8'd0;
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      div_cnt_q <= 8'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end
`else
  always_comb begin
    step_d = ft_d;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      col_q   <= 10'd0;
      row_q   <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b1;
      ft_q    <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      ft_q    <= ft_d;
      step_q  <= step_d;
    end
  end

  assign col        = col_q;
  assign row        = row_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign de         = de_q;
  assign frame_tick = ft_q;
  assign step       = step_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster and a time-based position model.
module tb_vga_timing_gen;

  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 20, VF = 3, VS = 2, VB = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] step_div = 8'd0;
  logic [9:0] col, row;
  logic       hsync, vsync, de, frame_tick, step;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
`ifdef VGA_STEP_DIV_EN
    .step_div  (step_div),
`endif
    .col       (col),
    .row       (row),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .frame_tick(frame_tick),
    .step      (step)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int t = 0;        // clocks since the last reset edge
  int n = 0;        // frame ticks counted toward the next step
  logic exp_step = 1'b0;

  function automatic int ecol(int tt); return tt % HT; endfunction
  function automatic int erow(int tt); return (tt / HT) % VT; endfunction
  function automatic logic ehs(int tt);
    return !(ecol(tt) >= HA + HF && ecol(tt) < HA + HF + HS);
  endfunction
  function automatic logic evs(int tt);
    return !(erow(tt) >= VA + VF && erow(tt) < VA + VF + VS);
  endfunction
  function automatic logic ede(int tt); return ecol(tt) < HA && erow(tt) < VA; endfunction
  function automatic logic eft(int tt); return ecol(tt) == 0 && erow(tt) == VA; endfunction

  task automatic adv();
    @(posedge CLK);
    exp_step = 1'b0;
    if (!RST) begin
      t = 0;
      n = 0;
    end else begin
      t++;
      if (eft(t)) begin
`ifdef VGA_STEP_DIV_EN
        if (n >= int'(step_div)) begin
          exp_step = 1'b1;
          n = 0;
        end else begin
          n++;
        end
`else
        exp_step = 1'b1;
`endif
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) adv();
    checks += 7;
    if (col !== 10'd0) begin errors++; $display("FAIL reset_col got %0d want 0", col); end
    if (row !== 10'd0) begin errors++; $display("FAIL reset_row got %0d want 0", row); end
    if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync); end
    if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync); end
    if (de !== 1'b1) begin errors++; $display("FAIL reset_de got %b want 1", de); end
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft got %b want 0", frame_tick); end
    if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b want 0", step); end
  endtask

  task automatic test_line();
    int lows = 0;
    int first = -1;
    RST = 1'b1;
    for (int i = 0; i < HT; i++) begin
      adv();
      checks += 2;
      if (col !== 10'(ecol(t))) begin
        errors++; $display("FAIL line_col got %0d want %0d", col, ecol(t));
      end
      if (row !== 10'(erow(t))) begin
        errors++; $display("FAIL line_row got %0d want %0d", row, erow(t));
      end
      if (hsync === 1'b0) begin
        if (first < 0) first = int'(col);
        lows++;
      end
    end
    checks += 2;
    if (lows != HS) begin errors++; $display("FAIL hsync_width got %0d want %0d", lows, HS); end
    if (first != HA + HF) begin
      errors++; $display("FAIL hsync_start got %0d want %0d", first, HA + HF);
    end
  endtask

  task automatic test_frame();
    int des = 0, vlows = 0, fts = 0, vfirst = -1;
    for (int i = 0; i < FT; i++) begin
      adv();
      checks += 6;
      if (col !== 10'(ecol(t)) || row !== 10'(erow(t))) begin
        errors++; $display("FAIL frame_pos got (%0d,%0d) want (%0d,%0d)", col, row, ecol(t), erow(t));
      end
      if (hsync !== ehs(t)) begin errors++; $display("FAIL frame_hsync got %b want %b", hsync, ehs(t)); end
      if (vsync !== evs(t)) begin errors++; $display("FAIL frame_vsync got %b want %b", vsync, evs(t)); end
      if (de !== ede(t)) begin errors++; $display("FAIL frame_de got %b want %b", de, ede(t)); end
      if (frame_tick !== eft(t)) begin
        errors++; $display("FAIL frame_ft got %b want %b", frame_tick, eft(t));
      end
      if (step !== exp_step) begin errors++; $display("FAIL frame_step got %b want %b", step, exp_step); end
      if (de === 1'b1) des++;
      if (frame_tick === 1'b1) fts++;
      if (vsync === 1'b0) begin
        if (vfirst < 0) vfirst = int'(row) * HT + int'(col);
        vlows++;
      end
    end
    checks += 4;
    if (des != HA * VA) begin errors++; $display("FAIL de_count got %0d want %0d", des, HA * VA); end
    if (vlows != VS * HT) begin errors++; $display("FAIL vsync_width got %0d want %0d", vlows, VS * HT); end
    if (vfirst != (VA + VF) * HT) begin
      errors++; $display("FAIL vsync_start got %0d want %0d", vfirst, (VA + VF) * HT);
    end
    if (fts != 1) begin errors++; $display("FAIL frame_ft_count got %0d want 1", fts); end
  endtask

  task automatic test_points();
    int pc [3] = '{HA, 0, HA - 1};
    int pr [3] = '{0, VA, VA - 1};
    logic pde [3] = '{1'b0, 1'b0, 1'b1};
    for (int p = 0; p < 3; p++) begin
      int k = 0;
      while (!(ecol(t) == pc[p] && erow(t) == pr[p]) && k < 2 * FT) begin
        adv();
        k++;
      end
      checks += 2;
      if (k >= 2 * FT) begin
        errors++; $display("FAIL point_seek timeout got %0d want <%0d", k, 2 * FT);
      end else begin
        if (col !== 10'(pc[p]) || row !== 10'(pr[p])) begin
          errors++; $display("FAIL point_pos got (%0d,%0d) want (%0d,%0d)", col, row, pc[p], pr[p]);
        end
        if (de !== pde[p]) begin
          errors++; $display("FAIL point_de at (%0d,%0d) got %b want %b", pc[p], pr[p], de, pde[p]);
        end
      end
    end
  endtask

  task automatic test_ticks();
    int ticks = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      adv();
      checks += 2;
      if (frame_tick !== eft(t)) begin errors++; $display("FAIL tick_ft got %b want %b", frame_tick, eft(t)); end
      if (step !== exp_step) begin errors++; $display("FAIL tick_step got %b want %b", step, exp_step); end
      if (frame_tick === 1'b1) begin
        ticks++;
        checks++;
        if (col !== 10'd0 || row !== 10'(VA)) begin
          errors++; $display("FAIL tick_pos got (%0d,%0d) want (0,%0d)", col, row, VA);
        end
      end
    end
    checks++;
    if (ticks != 3) begin errors++; $display("FAIL tick_count got %0d want 3", ticks); end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 4; r++) begin
      int tc = HA + HF + int'($urandom_range(1, HS - 1));
      int tr = (r == 0) ? (VA * 2) / 5 : int'($urandom_range(0, VT - 1));
      int k = 0;
      while (!(ecol(t) == tc && erow(t) == tr) && k < 2 * FT) begin
        adv();
        k++;
      end
      checks += 2;
      if (k >= 2 * FT) begin
        errors++; $display("FAIL mid_seek timeout got %0d want <%0d", k, 2 * FT);
      end
      if (hsync !== 1'b0) begin errors++; $display("FAIL mid_pre_hsync got %b want 0", hsync); end
      RST = 1'b0;
      adv();
      checks += 6;
      if (col !== 10'd0 || row !== 10'd0) begin
        errors++; $display("FAIL mid_pos got (%0d,%0d) want (0,0)", col, row);
      end
      if (hsync !== 1'b1) begin errors++; $display("FAIL mid_hsync got %b want 1", hsync); end
      if (vsync !== 1'b1) begin errors++; $display("FAIL mid_vsync got %b want 1", vsync); end
      if (de !== 1'b1) begin errors++; $display("FAIL mid_de got %b want 1", de); end
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL mid_ft got %b want 0", frame_tick); end
      if (step !== 1'b0) begin errors++; $display("FAIL mid_step got %b want 0", step); end
      RST = 1'b1;
      adv();
      checks++;
      if (col !== 10'd1 || row !== 10'd0) begin
        errors++; $display("FAIL mid_release got (%0d,%0d) want (1,0)", col, row);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len = int'($urandom_range(200, 3000));
      step_div = 8'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 999) == 0) RST = 1'b0;
        else RST = 1'b1;
        if ($urandom_range(0, 499) == 0) step_div = 8'($urandom_range(0, 3));
        adv();
        checks += 6;
        if (col !== 10'(ecol(t)) || row !== 10'(erow(t))) begin
          errors++; $display("FAIL rand_pos got (%0d,%0d) want (%0d,%0d)", col, row, ecol(t), erow(t));
        end
        if (hsync !== ehs(t)) begin errors++; $display("FAIL rand_hsync got %b want %b", hsync, ehs(t)); end
        if (vsync !== evs(t)) begin errors++; $display("FAIL rand_vsync got %b want %b", vsync, evs(t)); end
        if (de !== ede(t)) begin errors++; $display("FAIL rand_de got %b want %b", de, ede(t)); end
        if (frame_tick !== eft(t)) begin
          errors++; $display("FAIL rand_ft got %b want %b", frame_tick, eft(t));
        end
        if (step !== exp_step) begin errors++; $display("FAIL rand_step got %b want %b", step, exp_step); end
      end
    end
    RST = 1'b1;
  endtask

`ifdef VGA_STEP_DIV_EN
  task automatic test_step_div();
    int ticks = 0;
    int k = 0;
    RST = 1'b0;
    adv();
    RST = 1'b1;
    step_div = 8'd2;
    while (ticks < 9 && k < 10 * FT) begin
      adv();
      k++;
      if (frame_tick === 1'b1) begin
        ticks++;
        checks++;
        if (step !== ((ticks % 3) == 0)) begin
          errors++; $display("FAIL div2_step tick %0d got %b want %b", ticks, step, (ticks % 3) == 0);
        end
      end
    end
    step_div = 8'd0;
    ticks = 0;
    k = 0;
    while (ticks < 3 && k < 4 * FT) begin
      adv();
      k++;
      if (frame_tick === 1'b1) begin
        ticks++;
        checks++;
        if (step !== 1'b1) begin errors++; $display("FAIL div0_step tick %0d got %b want 1", ticks, step); end
      end
    end
    checks++;
    if (k >= 4 * FT) begin errors++; $display("FAIL div_timeout got %0d want <%0d", k, 4 * FT); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_points();
    test_ticks();
    test_reset_mid();
`ifdef VGA_STEP_DIV_EN
    test_step_div();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
